rr_mux4: RTL and testbench
==========================

Name: rr_mux4

Overview:
4-to-1 round-robin multiplexer with valid/ready handshake on every input channel and on the single output. It is the collecting end of the 1-to-4 demux path.
- Each accepted word is registered together with its 2-bit channel ID on `sel`.
- A downstream demux can use `sel` directly to route the word back out to one of four lines.

Parameters:
WIDTH, 8, data width of each input channel and of output `y`

Ports:
clk       input   1          single clock, rising edge
rst       input   1          synchronous, active-high reset
i         input   4*WIDTH    packed channel data; channel k = i[k*WIDTH +: WIDTH]
i_valid   input   4          per-channel valid
i_ready   output  4          per-channel ready; at most one bit high per cycle
y         output  WIDTH      registered output data
y_valid   output  1          output valid
y_ready   input   1          downstream ready
sel       output  2          channel ID of the word currently in `y`

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset values: y=0, sel=2'b00, y_valid=0, internal pointer ptr=2'b00. While rst=1, i_ready=4'b0000 (combinationally forced).
- Output register is one entry. load_en = !y_valid || y_ready.
- Arbitration (combinational):
  - Search i_valid starting at channel ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - The first set bit is the grant g.
  - i_ready = onehot(g) when load_en=1 and any i_valid is set; otherwise i_ready = 0.
  - i_ready never depends on i_valid of channels other than those searched; no combinational path from y_ready to y.
- Transfer on rising edge when load_en and some i_valid=1:
  - y <= channel g data; sel <= g; y_valid <= 1; ptr <= g+1 (wraps 3 -> 0).
- When load_en=1 and no i_valid is set: y_valid <= 0; y and sel hold their last values; ptr unchanged.
- Hold rule: while y_valid=1 and y_ready=0, y, sel and y_valid are stable and i_ready=0.
- Latency: input handshake at edge N -> word on y with y_valid=1 after edge N.
- Throughput: one word per cycle when y_ready is held high. Back-to-back output with no bubble.
- Fairness: with all four channels continuously valid, the grant order is 0,1,2,3,0,... Every channel is served within 4 accepted transfers.
- Simultaneous events:
  - A y consume and a new load in the same cycle is legal; the new word replaces the old one.
  - A channel granted in cycle N is lowest priority in cycle N+1.
- Reset mid-operation: a pending output word is discarded; y_valid=0 on the cycle after the reset edge. No input is acknowledged during reset.
- Input protocol expectation: a source holds its data stable while its i_valid=1 and its i_ready=0. The block does not check this.

Optional Feature:
Macro MUX_FIXED_PRI_EN.
- Defined: fixed priority, channel 0 highest and channel 3 lowest. ptr is not implemented; the search always starts at channel 0.
- Undefined (default): round-robin as described above.
- All other behaviour (handshake, latency, reset values) is identical in both builds.

Decomposition:
- Package `mux_pkg` holds:
  - localparam NUM_CH=4
  - localparam CH_W=2
  - typedef logic [CH_W-1:0] ch_id_t, used for sel, ptr and g
- Sub-module `rr_arbiter4`:
  - inputs: req[3:0], ptr (ch_id_t)
  - outputs: gnt[3:0] one-hot, gnt_id (ch_id_t), any_gnt
  - Purely combinational.
  - The MUX_FIXED_PRI_EN variant is selected inside this sub-module.
- `rr_mux4` contains the output register, load_en, ptr update and the data select.

Test Plan:
1. Reset: assert rst 2 cycles with i_valid=4'b1111 -> i_ready=0, y_valid=0, y=0, sel=0 throughout.
2. Single channel: WIDTH=8, i_valid=4'b0100, channel 2 data=8'hA5, y_ready=1 -> i_ready=4'b0100 for one cycle; next cycle y=8'hA5, sel=2, y_valid=1.
3. Round-robin: all channels valid with data 8'h10,8'h11,8'h12,8'h13, y_ready=1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3 and y sequence 10,11,12,13,10,...
4. Backpressure: y_valid=1 with y=8'h11, y_ready=0 for 3 cycles -> y, sel and y_valid stable, i_ready=0. Then y_ready=1 -> the next word loads on the same edge.
5. Wrap and skip: last grant=3, then i_valid=4'b0010 -> grant channel 1, sel=1, ptr becomes 2. Separately, i_valid drops to 0 while y_ready=1 -> y_valid=0 on the next cycle.
6. Mid-operation reset: rst=1 for one cycle while y_valid=1 -> y_valid=0, ptr=0, and the first grant after reset goes to the lowest valid channel at or after 0. Repeat test 3 with MUX_FIXED_PRI_EN defined -> sel=0 on every cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the 4-channel round-robin collector (rr_mux4 and its arbiter).
// Latency: none, this file holds only types, constants and a helper function.
// Backpressure: not applicable.
//
// Contents:
//   NUM_CH     number of input channels
//   CH_W       width of a channel ID
//   ch_id_t    channel ID type, used for sel, ptr and the grant index
//   ch_onehot  converts a channel ID into a one-hot channel mask
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef logic [CH_W-1:0] ch_id_t;

    // Expands a channel ID into a mask with exactly that channel's bit set.
    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_id_t id);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux4_if.sv
// Bundle of the four input channels and the single output channel of rr_mux4.
// Latency: none, this is wiring only.
// Backpressure: valid/ready on each input channel and on the output channel.
//
// Signals:
//   i        packed channel data, channel k = i[k*WIDTH +: WIDTH]
//   i_valid  per-channel valid        i_ready  per-channel ready (at most one high)
//   y        output data              y_valid  output valid
//   y_ready  downstream ready         sel      channel ID of the word in y
// Modports:
//   slave    the mux side: it takes the inputs and drives the output
//   master   the environment side: it drives the sources and the sink
interface rr_mux4_if #(
    parameter int WIDTH = 8
) ();

    logic [4*WIDTH-1:0]   i;
    logic [3:0]           i_valid;
    logic [3:0]           i_ready;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;
    logic                 y_ready;
    mux_pkg::ch_id_t      sel;

    modport slave (
        input  i,
        input  i_valid,
        output i_ready,
        output y,
        output y_valid,
        input  y_ready,
        output sel
    );

    modport master (
        output i,
        output i_valid,
        input  i_ready,
        input  y,
        input  y_valid,
        output y_ready,
        input  sel
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way arbiter: picks the first request at or after a start channel.
// Latency: purely combinational, no state.
// Backpressure: none here; the caller decides whether a grant is used.
//
// Ports:
//   req      request per channel
//   ptr      channel searched first (round-robin build); ignored in the fixed build
//   gnt      one-hot grant, all zero when nothing is requested
//   gnt_id   index of the granted channel (0 when nothing is requested)
//   any_gnt  at least one request is present
// Build option:
//   MUX_FIXED_PRI_EN defined: fixed priority, channel 0 highest and channel 3 lowest
//   MUX_FIXED_PRI_EN undefined: round-robin search starting at ptr
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_id_t            ptr,
    output logic [NUM_CH-1:0] gnt,
    output ch_id_t            gnt_id,
    output logic              any_gnt
);

    ch_id_t start;

`ifdef MUX_FIXED_PRI_EN
    // Search always starts at channel 0; ptr is carried for port compatibility only.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign start      = '0;
`else
    assign start = ptr;
`endif

    // Walk the channels from the furthest offset back towards start, so the
    // closest requesting channel (smallest offset from start) is written last
    // and wins. The 2-bit add wraps 3 -> 0 naturally.
    always_comb begin
        ch_id_t idx;
        idx     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = start + ch_id_t'(k);
            if (req[idx]) begin
                gnt_id  = idx;
                any_gnt = 1'b1;
            end
        end
    end

    assign gnt = any_gnt ? ch_onehot(gnt_id) : '0;

endmodule

// File: rtl/rr_mux4.sv
// 4-to-1 round-robin collector; each accepted word is registered with its channel ID on sel.
// Latency: one cycle, an input handshake on edge N makes the word visible on y after edge N.
// Backpressure: single output register; inputs are only acknowledged when it is empty or draining.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; forces i_ready low while asserted
//   bus      rr_mux4_if.slave: i/i_valid/i_ready inputs, y/y_valid/y_ready/sel output
// Parameter:
//   WIDTH    data width per channel; must match the WIDTH of the connected interface
// Build option:
//   MUX_FIXED_PRI_EN defined selects fixed priority (channel 0 highest) and drops ptr;
//   undefined (default) selects round-robin, where the last granted channel becomes
//   lowest priority for the following arbitration.
module rr_mux4
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    rr_mux4_if.slave   bus
);

    logic [NUM_CH-1:0] gnt;
    ch_id_t            gnt_id;
    logic              any_gnt;
    ch_id_t            ptr;
    logic              load_en;
    logic              take;

    logic [WIDTH-1:0]  y_q;
    ch_id_t            sel_q;
    logic              y_vld_q;

    logic [WIDTH-1:0]  ch_dat [NUM_CH];
    logic [WIDTH-1:0]  pick_dat;

    // Unpack the flat channel bus so the data select is a plain array index.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_dat[k] = bus.i[k*WIDTH +: WIDTH];
    end

    assign pick_dat = ch_dat[gnt_id];

    rr_arbiter4 u_arb (
        .req     (bus.i_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_gnt (any_gnt)
    );

    // The output register can accept a new word when it is empty or when its
    // current word is being consumed on this same edge.
    assign load_en = !y_vld_q || bus.y_ready;
    assign take    = load_en && any_gnt;

    // gnt is already all-zero when nothing is requested; reset masks every
    // acknowledge so no source believes a word was taken during reset.
    assign bus.i_ready = (!rst && load_en) ? gnt : '0;

`ifdef MUX_FIXED_PRI_EN
    assign ptr = '0;
`else
    // The channel after the one just granted is searched first next time,
    // which makes the granted channel lowest priority on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= gnt_id + ch_id_t'(1);
        end
    end
`endif

    // Output register. When load_en is high but nothing is requested the
    // register empties; y and sel keep their last values so a downstream
    // demux does not see needless toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            sel_q   <= '0;
            y_vld_q <= 1'b0;
        end else if (load_en) begin
            if (any_gnt) begin
                y_q     <= pick_dat;
                sel_q   <= gnt_id;
                y_vld_q <= 1'b1;
            end else begin
                y_vld_q <= 1'b0;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.sel     = sel_q;
    assign bus.y_valid = y_vld_q;

endmodule

// File: tb/tb_rr_mux4.sv
// Scoreboard bench for rr_mux4: directed stimulus pushes expected (sel, data) pairs,
// a monitor pops and compares on every output handshake.
module tb_rr_mux4;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] dat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    rr_mux4_if #(.WIDTH(8)) bus ();

    rr_mux4 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] d);
        exp_t e;
        e.sel = s;
        e.dat = d;
        sb.push_back(e);
    endtask

    task automatic base_data();
        bus.i = {8'h13, 8'h12, 8'h11, 8'h10};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(bus.y), 32'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    check("sb_sel", 32'(bus.sel), 32'(e.sel));
                    check("sb_y", 32'(bus.y), 32'(e.dat));
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst         = 1'b1;
        bus.i_valid = 4'b1111;
        bus.y_ready = 1'b1;
        base_data();

        // 1. Reset held two cycles with every channel requesting.
        for (int n = 0; n < 2; n++) begin
            tick();
            check("rst_i_ready", 32'(bus.i_ready), 32'h0);
            check("rst_y_valid", 32'(bus.y_valid), 32'h0);
            check("rst_y", 32'(bus.y), 32'h0);
            check("rst_sel", 32'(bus.sel), 32'h0);
        end

        // 2. Single channel 2 with data A5.
        rst = 1'b0;
        bus.i_valid = 4'b0100;
        bus.i[23:16] = 8'hA5;
        #1;
        check("single_i_ready", 32'(bus.i_ready), 32'h4);
        push(2'd2, 8'hA5);
        tick();
        bus.i_valid = 4'b0000;
        #1;
        check("single_y", 32'(bus.y), 32'hA5);
        check("single_sel", 32'(bus.sel), 32'h2);
        check("single_y_valid", 32'(bus.y_valid), 32'h1);
        check("single_i_ready_after", 32'(bus.i_ready), 32'h0);
        tick();
        // 5b. Inputs idle while y_ready=1: register empties, y/sel hold.
        check("idle_y_valid", 32'(bus.y_valid), 32'h0);
        check("idle_y_hold", 32'(bus.y), 32'hA5);
        check("idle_sel_hold", 32'(bus.sel), 32'h2);

        // 3. All channels valid for 8 cycles.
        do_reset();
        base_data();
        for (int n = 0; n < 8; n++) begin
`ifdef MUX_FIXED_PRI_EN
            push(2'd0, 8'h10);
`else
            push(2'(n % 4), 8'(8'h10 + (n % 4)));
`endif
        end
        bus.i_valid = 4'b1111;
        bus.y_ready = 1'b1;
        for (int n = 0; n < 8; n++) tick();
        bus.i_valid = 4'b0000;
        tick();
        check("rr_drain_y_valid", 32'(bus.y_valid), 32'h0);

        // 4. Backpressure with y=11 held for 3 cycles.
        do_reset();
        bus.i_valid = 4'b0010;
        bus.y_ready = 1'b0;
        push(2'd1, 8'h11);
        tick();
        bus.i_valid = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("bp_y", 32'(bus.y), 32'h11);
            check("bp_sel", 32'(bus.sel), 32'h1);
            check("bp_y_valid", 32'(bus.y_valid), 32'h1);
            check("bp_i_ready", 32'(bus.i_ready), 32'h0);
            tick();
        end
        bus.y_ready = 1'b1;
        #1;
`ifdef MUX_FIXED_PRI_EN
        check("bp_release_i_ready", 32'(bus.i_ready), 32'h1);
        push(2'd0, 8'h10);
`else
        check("bp_release_i_ready", 32'(bus.i_ready), 32'h4);
        push(2'd2, 8'h12);
`endif
        tick();
        check("bp_release_y_valid", 32'(bus.y_valid), 32'h1);
        bus.i_valid = 4'b0000;
        tick();

        // 5. Grant 3, wrap, then channel 1, then ptr=2 picks channel 2 over 1.
        do_reset();
        bus.i_valid = 4'b1000;
        push(2'd3, 8'h13);
        tick();
        bus.i_valid = 4'b0010;
        #1;
        check("wrap_i_ready", 32'(bus.i_ready), 32'h2);
        push(2'd1, 8'h11);
        tick();
        bus.i_valid = 4'b0110;
        #1;
`ifdef MUX_FIXED_PRI_EN
        check("ptr2_i_ready", 32'(bus.i_ready), 32'h2);
        push(2'd1, 8'h11);
`else
        check("ptr2_i_ready", 32'(bus.i_ready), 32'h4);
        push(2'd2, 8'h12);
`endif
        tick();
        bus.i_valid = 4'b0000;
        tick();
        check("skip_idle_y_valid", 32'(bus.y_valid), 32'h0);

        // 6. Reset while a word is pending; ptr must restart at 0.
        bus.i_valid = 4'b0100;
        bus.y_ready = 1'b0;
        tick();
        check("pend_y_valid", 32'(bus.y_valid), 32'h1);
        rst = 1'b1;
        bus.i_valid = 4'b1111;
        #1;
        check("mid_rst_i_ready", 32'(bus.i_ready), 32'h0);
        tick();
        check("mid_rst_y_valid", 32'(bus.y_valid), 32'h0);
        check("mid_rst_y", 32'(bus.y), 32'h0);
        check("mid_rst_sel", 32'(bus.sel), 32'h0);
        rst = 1'b0;
        bus.i_valid = 4'b1110;
        bus.y_ready = 1'b1;
        #1;
        check("post_rst_i_ready", 32'(bus.i_ready), 32'h2);
        push(2'd1, 8'h11);
        tick();
        bus.i_valid = 4'b0000;
        tick();

        // Every expected word must have been consumed, within a bounded wait.
        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
